// File: rtl/mont_pkg.sv
// mont_pkg -- shared definitions for the Montgomery exponentiation controller.
//   DEFAULT_WIDTH : default operand width in bits
//   state_t       : controller state encoding
//   operand_t     : operand vector at the default width
package mont_pkg;

    localparam int unsigned DEFAULT_WIDTH = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE_T,
        ST_PRE_M,
        ST_MUL,
        ST_SQR,
        ST_POST,
        ST_FIN
    } state_t;

    typedef logic [DEFAULT_WIDTH-1:0] operand_t;

endpackage

// File: rtl/mont_exp_ctrl.sv
// mont_exp_ctrl -- right-to-left binary modular exponentiation (Y^E mod N)
// sequenced over an external Montgomery multiplier.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              one-cycle request, sampled only while idle
//   Y, E, N, R2        message, exponent, odd modulus, 2^(2*WIDTH) mod N
//   busy               high while an exponentiation is in progress
//   done, out          one-cycle completion pulse and held result
//   mm_start           one-cycle request to the multiplier
//   mm_a, mm_b, mm_n   multiplier operands, stable until mm_done
//   mm_out, mm_done    multiplier result and its one-cycle valid pulse
//
// Build option: MONT_EXP_EARLY_TERM_EN -- when defined, stop squaring once
// no set exponent bits remain above the current bit; the result is unchanged.
module mont_exp_ctrl
    import mont_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] Y,
    input  logic [WIDTH-1:0] E,
    input  logic [WIDTH-1:0] N,
    input  logic [WIDTH-1:0] R2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             mm_start,
    output logic [WIDTH-1:0] mm_a,
    output logic [WIDTH-1:0] mm_b,
    output logic [WIDTH-1:0] mm_n,
    input  logic [WIDTH-1:0] mm_out,
    input  logic             mm_done
);

    localparam int unsigned     CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    state_t           r_state;
    state_t           w_next;
    logic             w_issue;
    logic             r_mm_start;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_e;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_r2;
    logic [WIDTH-1:0] r_t;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_out;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_inc;
    state_t           w_sqr_cur;
    state_t           w_sqr_nxt;

    assign w_cnt_inc = r_cnt + 1'b1;

    // w_sqr_cur: destination from PRE_M/MUL when the current bit needs no
    // further multiply; r_e[0] is the current bit.
    // w_sqr_nxt: destination from SQR when the next bit (r_e[1]) is zero;
    // after the shift the bits above it are r_e[WIDTH-1:2].
`ifdef MONT_EXP_EARLY_TERM_EN
    assign w_sqr_cur = ((r_e >> 1) == '0) ? ST_POST : ST_SQR;
    assign w_sqr_nxt = ((r_e >> 2) == '0) ? ST_POST : ST_SQR;
`else
    assign w_sqr_cur = ST_SQR;
    assign w_sqr_nxt = ST_SQR;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Every op-state completion launches the next op except POST -> FIN,
    // so w_issue also covers SQR -> SQR re-entry.
    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next  = ST_PRE_T;
                    w_issue = 1'b1;
                end
            end
            ST_PRE_T: begin
                if (mm_done) begin
                    w_next  = ST_PRE_M;
                    w_issue = 1'b1;
                end
            end
            ST_PRE_M: begin
                if (mm_done) begin
                    w_next  = r_e[0] ? ST_MUL : w_sqr_cur;
                    w_issue = 1'b1;
                end
            end
            ST_MUL: begin
                if (mm_done) begin
                    w_next  = w_sqr_cur;
                    w_issue = 1'b1;
                end
            end
            ST_SQR: begin
                if (mm_done) begin
                    if (w_cnt_inc == CNT_LAST) begin
                        w_next = ST_POST;
                    end else if (r_e[1]) begin
                        w_next = ST_MUL;
                    end else begin
                        w_next = w_sqr_nxt;
                    end
                    w_issue = 1'b1;
                end
            end
            ST_POST: begin
                if (mm_done) begin
                    w_next = ST_FIN;
                end
            end
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mm_start <= 1'b0;
            r_y        <= '0;
            r_e        <= '0;
            r_n        <= '0;
            r_r2       <= '0;
            r_t        <= '0;
            r_m        <= '0;
            r_out      <= '0;
            r_cnt      <= '0;
        end else begin
            r_mm_start <= w_issue;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_y   <= Y;
                        r_e   <= E;
                        r_n   <= N;
                        r_r2  <= R2;
                        r_cnt <= '0;
                    end
                end
                ST_PRE_T: if (mm_done) r_t <= mm_out;
                ST_PRE_M: if (mm_done) r_m <= mm_out;
                ST_MUL:   if (mm_done) r_m <= mm_out;
                ST_SQR: begin
                    if (mm_done) begin
                        r_t   <= mm_out;
                        r_cnt <= w_cnt_inc;
                        r_e   <= r_e >> 1;
                    end
                end
                ST_POST: begin
                    // Result is captured here so it is already valid in FIN.
                    if (mm_done) begin
                        r_m   <= mm_out;
                        r_out <= mm_out;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mm_a = '0;
        mm_b = '0;
        case (r_state)
            ST_PRE_T: begin mm_a = r_y;  mm_b = r_r2; end
            ST_PRE_M: begin mm_a = r_r2; mm_b = ONE;  end
            ST_MUL:   begin mm_a = r_m;  mm_b = r_t;  end
            ST_SQR:   begin mm_a = r_t;  mm_b = r_t;  end
            ST_POST:  begin mm_a = r_m;  mm_b = ONE;  end
            default:  ;
        endcase
    end

    assign mm_n     = r_n;
    assign mm_start = r_mm_start;
    assign busy     = (r_state != ST_IDLE) && (r_state != ST_FIN);
    assign done     = (r_state == ST_FIN);
    assign out      = r_out;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// tb_mont_exp_ctrl -- self-checking bench for mont_exp_ctrl (WIDTH=256).
// Provides a behavioural Montgomery multiplier peer with fixed latency and
// checks results against a plain modular-arithmetic reference.
module tb_mont_exp_ctrl;

    localparam int unsigned W   = 256;
    localparam int unsigned LAT = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] Y, E, N, R2;
    logic         busy, done;
    logic [W-1:0] out;
    logic         mm_start;
    logic [W-1:0] mm_a, mm_b, mm_n;
    logic [W-1:0] mm_out;
    logic         mm_done;

    int checks = 0;
    int errors = 0;

    int unsigned  mm_starts = 0;
    int unsigned  pend = 0;
    logic [W-1:0] pend_res, cap_a, cap_b, cap_n;
    bit           stale = 1'b0;
    bit           stray_req = 1'b0;

    always #5 clk = ~clk;

    mont_exp_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .Y        (Y),
        .E        (E),
        .N        (N),
        .R2       (R2),
        .busy     (busy),
        .done     (done),
        .out      (out),
        .mm_start (mm_start),
        .mm_a     (mm_a),
        .mm_b     (mm_b),
        .mm_n     (mm_n),
        .mm_out   (mm_out),
        .mm_done  (mm_done)
    );

    task automatic chk_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // a*b*2^-W mod n, fully reduced
    function automatic logic [W-1:0] mont_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [W-1:0] n);
        logic [2*W+1:0] t, nn;
        nn = {{(W+2){1'b0}}, n};
        t  = {{(W+2){1'b0}}, a} * {{(W+2){1'b0}}, b};
        for (int i = 0; i < int'(W); i++) begin
            if (t[0]) t = t + nn;
            t = t >> 1;
        end
        if (t >= nn) t = t - nn;
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] calc_r2(input logic [W-1:0] n);
        logic [2*W:0] p;
        p = '0;
        p[2*W] = 1'b1;
        p = p % {{(W+1){1'b0}}, n};
        return p[W-1:0];
    endfunction

    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] y, input logic [W-1:0] e,
                                                input logic [W-1:0] n);
        logic [2*W-1:0] base, acc, nn;
        nn   = {{W{1'b0}}, n};
        base = {{W{1'b0}}, y} % nn;
        acc  = (n == W'(1)) ? '0 : (2*W)'(1);
        for (int i = 0; i < int'(W); i++) begin
            if (e[i]) acc = (acc * base) % nn;
            base = (base * base) % nn;
        end
        return acc[W-1:0];
    endfunction

    function automatic int unsigned exp_ops(input logic [W-1:0] e);
        int unsigned pc, msb, r;
        pc  = 0;
        msb = 0;
        for (int i = 0; i < int'(W); i++) begin
            if (e[i]) begin
                pc++;
                msb = i;
            end
        end
`ifdef MONT_EXP_EARLY_TERM_EN
        if (e == '0) r = 3;
        else         r = 3 + pc + msb;
`else
        r = 3 + W + pc;
`endif
        return r;
    endfunction

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] v;
        for (int i = 0; i < int'(W / 32); i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Behavioural multiplier peer
    initial begin
        mm_done = 1'b0;
        mm_out  = '0;
        forever begin
            @(negedge clk);
            mm_done = 1'b0;
            if (pend != 0) begin
                pend--;
                if (pend == 0) begin
                    mm_done = 1'b1;
                    mm_out  = pend_res;
                    if (!stale) begin
                        chk_w("mm_a_held", mm_a, cap_a);
                        chk_w("mm_b_held", mm_b, cap_b);
                        chk_w("mm_n_held", mm_n, cap_n);
                    end
                end
            end
            if (stray_req) begin
                stray_req = 1'b0;
                mm_done   = 1'b1;
                mm_out    = '1;
            end
            if (mm_start === 1'b1) begin
                if (!stale) chk_i("mm_start_overlap", longint'(pend), 0);
                cap_a    = mm_a;
                cap_b    = mm_b;
                cap_n    = mm_n;
                pend_res = mont_mul(mm_a, mm_b, mm_n);
                pend     = LAT;
                mm_starts++;
            end
        end
    end

    task automatic run_op(input logic [W-1:0] y, input logic [W-1:0] e, input logic [W-1:0] n,
                          input int glitch_at, output logic [W-1:0] res,
                          output int unsigned ops, output int unsigned ndone);
        int unsigned s0;
        bit ok;
        @(negedge clk);
        stale = 1'b0;
        Y     = y;
        E     = e;
        N     = n;
        R2    = calc_r2(n);
        start = 1'b1;
        s0    = mm_starts;
        @(negedge clk);
        start = 1'b0;
        chk_i("busy_after_start", longint'(busy), 1);
        ndone = 0;
        ok    = 1'b0;
        res   = '0;
        for (int cyc = 0; cyc < 20000 && !ok; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == glitch_at) begin
                Y     = ~y;
                E     = W'(3);
                start = 1'b1;
            end
            if (done) begin
                ndone++;
                res = out;
                ok  = 1'b1;
            end
        end
        ops = mm_starts - s0;
        if (!ok) chk_i("done_timeout", 0, 1);
        repeat (3) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk_i("busy_after_done", longint'(busy), 0);
        chk_w("out_holds", out, res);
    endtask

    typedef struct {
        logic [W-1:0] y;
        logic [W-1:0] e;
        logic [W-1:0] n;
        logic [W-1:0] want;
        int           glitch;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [W-1:0] res, ebig, tmp;
        int unsigned  ops, ndone, s0, bad;
        int unsigned  ops_e15;

        vecs[0] = '{W'(4),   W'(13), W'(497), W'(445), -1};
        vecs[1] = '{W'(7),   W'(0),  W'(497), W'(1),   -1};
        vecs[2] = '{W'(500), W'(1),  W'(497), W'(3),   -1};
        vecs[3] = '{W'(4),   W'(15), W'(497), ref_modexp(W'(4), W'(15), W'(497)), -1};
        vecs[4] = '{W'(4),   W'(13), W'(497), W'(445), 50};
        for (int i = 5; i < 8; i++) begin
            tmp = rand_wide();
            tmp[0] = 1'b1;
            tmp[W-1] = 1'b1;
            vecs[i].n = tmp;
            vecs[i].y = rand_wide();
            vecs[i].e = (i == 7) ? {{(W-16){1'b0}}, 16'($urandom)} : rand_wide();
            vecs[i].want = ref_modexp(vecs[i].y, vecs[i].e, vecs[i].n);
            vecs[i].glitch = -1;
        end
        ops_e15 = 0;

        rst_n = 1'b0;
        start = 1'b0;
        Y = '0; E = '0; N = '0; R2 = '0;
        repeat (2) @(negedge clk);
        chk_i("reset_busy", longint'(busy), 0);
        chk_i("reset_done", longint'(done), 0);
        chk_i("reset_mm_start", longint'(mm_start), 0);
        chk_w("reset_out", out, '0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].y, vecs[i].e, vecs[i].n, vecs[i].glitch, res, ops, ndone);
            chk_w($sformatf("vec%0d_result", i), res, vecs[i].want);
            chk_i($sformatf("vec%0d_done_pulses", i), longint'(ndone), 1);
            chk_i($sformatf("vec%0d_op_count", i), longint'(ops), longint'(exp_ops(vecs[i].e)));
            if (i == 3) ops_e15 = ops;
        end
`ifdef MONT_EXP_EARLY_TERM_EN
        chk_i("opcount_E15", longint'(ops_e15), 10);
`else
        chk_i("opcount_E15", longint'(ops_e15), 263);
`endif

        // Reset during the squaring of exponent bit 100 (106th operation).
        ebig = '0;
        ebig[200] = 1'b1;
        ebig[3:0] = 4'hD;
        @(negedge clk);
        stale = 1'b0;
        Y = W'(4); E = ebig; N = W'(497); R2 = calc_r2(W'(497));
        start = 1'b1;
        s0 = mm_starts;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 5000 && (mm_starts - s0) < 106; cyc++) @(negedge clk);
        chk_i("reach_sqr_bit100", longint'(mm_starts - s0), 106);
        @(negedge clk);
        chk_i("busy_before_reset", longint'(busy), 1);
        #2;
        rst_n = 1'b0;
        stale = 1'b1;
        #1;
        chk_i("abort_busy", longint'(busy), 0);
        chk_i("abort_mm_start", longint'(mm_start), 0);
        chk_i("abort_done", longint'(done), 0);
        chk_w("abort_out", out, '0);
        @(negedge clk);
        rst_n = 1'b1;
        stray_req = 1'b1;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy || mm_start || done) bad++;
        end
        chk_i("ignore_stray_mm_done", longint'(bad), 0);
        chk_w("out_after_stray", out, '0);

        run_op(W'(4), W'(13), W'(497), -1, res, ops, ndone);
        chk_w("rerun_result", res, W'(445));
        chk_i("rerun_done_pulses", longint'(ndone), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mont_exp_ctrl.md
MONT_EXP_CTRL -- requirements
Module: mont_exp_ctrl

Interface
REQ-001 Parameter WIDTH, default 256: operand width in bits.
REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 Port start, input, 1: one-cycle request; sampled only while idle.
REQ-005 Port Y, E, N, R2, inputs, WIDTH each: message, exponent, odd modulus, and 2^(2*WIDTH) mod N.
REQ-006 Port busy, output, 1: high while an exponentiation is in progress.
REQ-007 Port done, output, 1: one-cycle pulse when out is valid.
REQ-008 Port out, output, WIDTH: result Y^E mod N.
REQ-009 Port mm_start, output, 1: one-cycle request pulse to the external Montgomery multiplier.
REQ-010 Port mm_a, mm_b, mm_n, outputs, WIDTH each: multiplier operands; held stable from mm_start until mm_done.
REQ-011 Port mm_out, input, WIDTH: multiplier result, mm_a*mm_b*2^(-WIDTH) mod mm_n.
REQ-012 Port mm_done, input, 1: one-cycle pulse; mm_out is valid in that cycle.

Function
REQ-013 States: IDLE, PRE_T, PRE_M, MUL, SQR, POST, FIN.
- Exactly one multiplier operation is outstanding in each non-IDLE/FIN state.
REQ-014 IDLE, start=1:
- latch Y, E, N and R2;
- bit counter := 0;
- enter PRE_T; busy goes high next cycle.
REQ-015 Each op state asserts mm_start for exactly one cycle, on the first cycle after entering the state, then waits for mm_done.
REQ-016 PRE_T: T := Mont(Y, R2). On mm_done go to PRE_M.
REQ-017 PRE_M: M := Mont(R2, 1). On mm_done go to MUL if E[0]=1, else SQR.
REQ-018 MUL: M := Mont(M, T). On mm_done go to SQR.
REQ-019 SQR: T := Mont(T, T).
- On mm_done the counter increments and the exponent register shifts right by one.
- If counter = WIDTH go to POST; else go to MUL if the new LSB is 1, else SQR.
REQ-020 POST: M := Mont(M, 1). On mm_done go to FIN.
REQ-021 FIN:
- out := M, done=1 for one cycle, busy=0;
- return to IDLE;
- out holds its value until the next FIN.
REQ-022 start while busy is ignored; latched operands do not change.
REQ-023 mm_done while in IDLE or FIN is ignored.
REQ-024 mm_done in the same cycle as a new mm_start is impossible: a new mm_start is issued no earlier than the cycle after mm_done.
REQ-025 E=0 yields out = 1 (for N>1).
- Operation count without early termination: 2 + WIDTH + popcount(E) + 1.

Reset
REQ-026 rst_n=0 forces, asynchronously:
- state=IDLE;
- busy=0, done=0, mm_start=0, out=0, counter=0;
- operand registers cleared.
REQ-027 Reset mid-operation abandons the computation.
- Any later mm_done for the abandoned operation is ignored per REQ-023.

Configuration
REQ-028 Macro MONT_EXP_EARLY_TERM_EN.
- When defined: if all remaining exponent bits above the current bit are zero, the next transition that would enter SQR enters POST instead.
- When not defined: exactly WIDTH squarings are always performed.
- out is identical in both builds.

Structure
REQ-029 Package mont_pkg holds:
- the WIDTH default constant;
- the state enum typedef;
- the operand vector typedef.
REQ-030 No sub-module; the Montgomery multiplier remains an external peer connected through the mm_* ports.

Verification
REQ-031 Bench provides a behavioural multiplier with 5-cycle mm_done latency and a reference model; R2 is computed by the model.
REQ-032 Test 1, basic result: Y=4, E=13, N=497 -> out=445, done pulses once.
REQ-033 Test 2, exponent edge cases:
- E=0, Y=7, N=497 -> out=1.
- E=1, Y=500, N=497 -> out=3.
REQ-034 Test 3, operation count: E=0xF.
- Without macro: 263 mm_start pulses.
- With macro: 10 mm_start pulses.
- out equal in both builds.
REQ-035 Test 4, start while busy: pulse start with different Y mid-run -> ignored; result matches the first operands.
REQ-036 Test 5, reset mid-operation: rst_n low during SQR of bit 100 -> busy=0, mm_start=0 immediately.
- A stray mm_done afterwards is ignored.
- A new run with Y=4, E=13, N=497 -> 445.
